wb_stage: RTL

//  Write-back stage; consumes es_to_ws_bus from the execute/memory stage. Holds one instruction
//  per valid/allowin handshake. For loads, waits for the dcache response, then aligns and

---
 rtl/wb_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Purpose : write-back stage; holds one instruction, waits for the dcache on loads, then
//           aligns/extends the load data and retires to the register file, forward bus and trace.
// Latency : retire outputs are combinational from stage state; a non-load retires the cycle
//           after acceptance, a load retires in the same cycle dcache_rvalid arrives.
// Backpressure: ws_allowin = !ws_valid || ready_go, so back-to-back entry is 1 instr/cycle and
//           a load waiting for data stalls upstream.
// Ports   : clk/reset (sync, active-high); es_to_ws_valid/es_to_ws_bus/ws_allowin upstream
//           handshake; dcache_rvalid/dcache_rdata load return; rf_* register file write;
//           ws_forward_bus/ws_load_busy/ws_busy_dest bypass and hazard info; debug_wb_* trace;
//           retire_count and sticky mem_timeout status.
module wb_stage #(
    parameter int BUS_WD  = 76,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_to_ws_valid,
    input  logic [BUS_WD-1:0] es_to_ws_bus,
    output logic              ws_allowin,
    input  logic              dcache_rvalid,
    input  logic [31:0]       dcache_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [36:0]       ws_forward_bus,
    output logic              ws_load_busy,
    output logic [4:0]        ws_busy_dest,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata,
    output logic [CNT_W-1:0]  retire_count,
    output logic              mem_timeout
);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t            state, state_nxt;
    logic              ws_valid;
    logic [BUS_WD-1:0] bus_r;
    logic [31:0]       data_r;
    logic [7:0]        wait_cnt;

    // Payload fields of the held instruction.
    logic        is_load, ld_uns, gr_we;
    logic [1:0]  ld_size, addr_lo;
    logic [4:0]  dest;
    logic [31:0] result, pc;

    assign is_load = bus_r[75];
    assign ld_uns  = bus_r[74];
    assign ld_size = bus_r[73:72];
    assign addr_lo = bus_r[71:70];
    assign gr_we   = bus_r[69];
    assign dest    = bus_r[68:64];
    assign result  = bus_r[63:32];
    assign pc      = bus_r[31:0];

    logic        ready_go, retire, accept, wait_miss;
    logic [31:0] ld_word, ld_data, final_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ready_go = 1'b0;
        case (state)
            HOLD:    ready_go = 1'b1;
            WAIT:    ready_go = dcache_rvalid;
            default: ready_go = 1'b0;
        endcase
    end

    assign retire     = ws_valid && ready_go;
    assign ws_allowin = !ws_valid || ready_go;
    assign accept     = es_to_ws_valid && ws_allowin;
    assign wait_miss  = (state == WAIT) && !dcache_rvalid;

    // In WAIT the returning word is used directly so the load retires in the rvalid cycle.
    assign ld_word = (state == WAIT) ? dcache_rdata : data_r;

    always_comb begin
        ld_byte = ld_word[8*addr_lo +: 8];
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            2'b00:   ld_data = {{24{!ld_uns && ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{!ld_uns && ld_half[15]}}, ld_half};
            default: ld_data = ld_word;   // 10 and 11 are both whole-word loads
        endcase
    end

    assign final_data = is_load ? ld_data : result;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = es_to_ws_bus[75] ? WAIT : HOLD;
        end else if (retire) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ws_valid     <= 1'b0;
            bus_r        <= '0;
            data_r       <= '0;
            wait_cnt     <= '0;
            retire_count <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus_r    <= es_to_ws_bus;
                ws_valid <= 1'b1;
            end else if (retire) begin
                ws_valid <= 1'b0;
            end
            if ((state == WAIT) && dcache_rvalid) begin
                data_r <= dcache_rdata;
            end
            if (retire) begin
                retire_count <= retire_count + 1'b1;
            end
            if (accept) begin
                wait_cnt <= '0;
            end else if (wait_miss && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // Flag on the miss cycle that brings the count up to TIMEOUT.
            if (wait_miss && ((int'(wait_cnt) + 1) >= TIMEOUT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Register-file and trace outputs are driven only in the retire cycle, zero otherwise.
    assign rf_we    = retire && gr_we && (dest != 5'd0);
    assign rf_waddr = retire ? dest : 5'd0;
    assign rf_wdata = retire ? final_data : 32'd0;

    // Nothing is forwarded for dest 0 since r0 never changes.
    assign ws_forward_bus = rf_we ? {final_data, dest} : 37'd0;

    assign ws_load_busy = ws_valid && wait_miss;
    assign ws_busy_dest = ws_load_busy ? dest : 5'd0;

    assign debug_wb_pc       = retire ? pc : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
